// File: rtl/toggle_event_decoder.sv
// Receive side of a toggle-signalling link: synchronises the remote toggle, turns each level
// change into one event, buffers up to MAX_PENDING events and acks each delivery by a toggle.
module toggle_event_decoder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_PENDING = 7,
  parameter int unsigned PEND_W      = 3,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              input_clock_c,
  input  logic              input_clear_n,
  input  logic              input_toggle_t,
  input  logic              input_ready,
  output logic              output_event_valid,
  output logic [PEND_W-1:0] output_pending,
  output logic [CNT_W-1:0]  output_event_count,
  output logic              output_ack_t,
  output logic              output_overflow
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must lie in 2..4");
  end
  if (MAX_PENDING < 1 || MAX_PENDING > 15) begin : g_bad_max
    $error("MAX_PENDING must lie in 1..15");
  end
  if ((2 ** PEND_W) <= MAX_PENDING) begin : g_bad_width
    $error("PEND_W too narrow to hold MAX_PENDING");
  end

  localparam logic [PEND_W-1:0] MaxPend = PEND_W'(MAX_PENDING);

  typedef enum logic [1:0] {StEmpty, StHold, StFull} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  state_e                 state_q, state_d;
  logic [PEND_W-1:0]      pend_q, pend_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   valid_q, ack_q, ovf_q, ovf_d;
  logic                   ev_edge, xfer, accept, has_room;

  assign ev_edge  = sync_q[SYNC_STAGES-1] ^ hist_q;
  assign xfer     = valid_q & input_ready;
  assign has_room = (pend_q < MaxPend);
  // A coincident transfer frees a slot, so the event is kept even when full.
  assign accept   = ev_edge & (xfer | has_room);

  always_comb begin
    pend_d = pend_q;
    if (ev_edge && !xfer) begin
      if (has_room) pend_d = pend_q + 1'b1;
    end else if (xfer && !ev_edge) begin
      pend_d = pend_q - 1'b1;
    end

    cnt_d = accept ? cnt_q + 1'b1 : cnt_q;
    ovf_d = ovf_q | (ev_edge & ~xfer & ~has_room);

    if (pend_d == '0) begin
      state_d = StEmpty;
    end else if (pend_d == MaxPend) begin
      state_d = StFull;
    end else begin
      state_d = StHold;
    end
  end

  always_ff @(posedge input_clock_c or negedge input_clear_n) begin
    if (!input_clear_n) begin
      sync_q  <= '0;
      hist_q  <= 1'b0;
      state_q <= StEmpty;
      pend_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], input_toggle_t};
      hist_q  <= sync_q[SYNC_STAGES-1];
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      valid_q <= (pend_d != '0);
      ack_q   <= ack_q ^ xfer;
      ovf_q   <= ovf_d;
    end
  end

  // The state register mirrors the pending count; keep the two consistent.
  assert property (@(posedge input_clock_c) disable iff (!input_clear_n)
    ((state_q == StEmpty) == (pend_q == '0)) && ((state_q == StFull) == (pend_q == MaxPend)));

  assign output_event_valid = valid_q;
  assign output_pending     = pend_q;
  assign output_event_count = cnt_q;
  assign output_ack_t       = ack_q;
  assign output_overflow    = ovf_q;

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Bench for toggle_event_decoder: directed scenarios plus random toggling/ready, all checked
// every cycle against an event-queue model driven by a delayed copy of the toggle line.
module tb_toggle_event_decoder;

  localparam int unsigned S    = 2;
  localparam int unsigned MAXP = 7;
  localparam int unsigned PW   = 3;
  localparam int unsigned CW   = 8;

  logic          clk = 1'b0;
  logic          clear_n = 1'b0;
  logic          toggle = 1'b0;
  logic          ready = 1'b0;
  logic          valid;
  logic [PW-1:0] pending;
  logic [CW-1:0] count;
  logic          ack;
  logic          ovf;

  int n_chk = 0;
  int n_fail = 0;

  // Model state
  int m_pend, m_cnt;
  bit m_ack, m_ovf;
  bit hq[$];

  always #5 clk = ~clk;

  toggle_event_decoder #(
    .SYNC_STAGES(S),
    .MAX_PENDING(MAXP),
    .PEND_W     (PW),
    .CNT_W      (CW)
  ) dut (
    .input_clock_c     (clk),
    .input_clear_n     (clear_n),
    .input_toggle_t    (toggle),
    .input_ready       (ready),
    .output_event_valid(valid),
    .output_pending    (pending),
    .output_event_count(count),
    .output_ack_t      (ack),
    .output_overflow   (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0;
    m_cnt  = 0;
    m_ack  = 0;
    m_ovf  = 0;
    hq.delete();
    for (int i = 0; i < S + 1; i++) hq.push_back(1'b0);
  endtask

  // The toggle level seen S+1 edges ago versus S edges ago defines this edge's event.
  function automatic bit model_edge_next();
    return hq[0] ^ hq[1];
  endfunction

  task automatic model_step();
    bit e, t;
    e = model_edge_next();
    t = (m_pend != 0) && ready;
    if (e) begin
      if (t || m_pend < int'(MAXP)) m_cnt = (m_cnt + 1) % (1 << CW);
      else m_ovf = 1;
    end
    if (e && !t && m_pend < int'(MAXP)) m_pend++;
    if (t && !e) m_pend--;
    if (t) m_ack = ~m_ack;
    void'(hq.pop_front());
    hq.push_back(toggle);
  endtask

  task automatic check_all();
    chk("valid", 32'(valid), 32'(m_pend != 0));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("event_count", 32'(count), 32'(m_cnt));
    chk("ack_t", 32'(ack), 32'(m_ack));
    chk("overflow", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // Asserts clear between edges, checks the asynchronous effect, releases on the next negedge.
  task automatic do_clear(input bit lvl);
    @(negedge clk);
    toggle  = lvl;
    clear_n = 1'b0;
    #1;
    chk("clr_valid", 32'(valid), 32'd0);
    chk("clr_pending", 32'(pending), 32'd0);
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_ack", 32'(ack), 32'd0);
    chk("clr_overflow", 32'(ovf), 32'd0);
    model_reset();
    @(negedge clk);
    clear_n = 1'b1;
  endtask

  task automatic flips(input int n, input int gap);
    repeat (n) begin
      toggle = ~toggle;
      run(gap);
    end
  endtask

  initial begin
    int waited;
    int held;
    int thr;
    model_reset();

    // T1: first event latency
    do_clear(1'b0);
    ready  = 1'b0;
    toggle = 1'b1;
    run(2);
    chk("t1_valid_edge2", 32'(valid), 32'd0);
    cycle();
    chk("t1_valid_edge3", 32'(valid), 32'd1);
    chk("t1_pending", 32'(pending), 32'd1);
    chk("t1_count", 32'(count), 32'd1);
    chk("t1_ack", 32'(ack), 32'd0);

    // T2: buffer four then drain
    do_clear(1'b0);
    flips(4, 6);
    run(4);
    chk("t2_pending4", 32'(pending), 32'd4);
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t2_drain", 32'(pending), 32'(3 - i));
    end
    chk("t2_ack", 32'(ack), 32'd0);
    chk("t2_valid", 32'(valid), 32'd0);
    ready = 1'b0;

    // T3: overflow when full
    do_clear(1'b0);
    flips(8, 3);
    run(4);
    chk("t3_pending", 32'(pending), 32'd7);
    chk("t3_overflow", 32'(ovf), 32'd1);
    chk("t3_count", 32'(count), 32'd7);
    ready = 1'b1;
    run(9);
    chk("t3_drained", 32'(pending), 32'd0);
    chk("t3_sticky", 32'(ovf), 32'd1);
    ready = 1'b0;

    // T4: edge coincides with transfer while full
    do_clear(1'b0);
    flips(7, 3);
    run(4);
    chk("t4_full", 32'(pending), 32'd7);
    toggle = ~toggle;
    waited = 0;
    while (!model_edge_next() && waited < 10) begin
      cycle();
      waited++;
    end
    chk("t4_wait_bound", 32'(waited < 10), 32'd1);
    ready = 1'b1;
    cycle();
    ready = 1'b0;
    chk("t4_pending", 32'(pending), 32'd7);
    chk("t4_count", 32'(count), 32'd8);
    chk("t4_ack", 32'(ack), 32'd1);
    chk("t4_overflow", 32'(ovf), 32'd0);

    // T5: counter wrap under continuous ready
    do_clear(1'b0);
    ready = 1'b1;
    flips(256, 2);
    run(5);
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_ack", 32'(ack), 32'd0);
    chk("t5_overflow", 32'(ovf), 32'd0);
    chk("t5_pending", 32'(pending), 32'd0);
    ready = 1'b0;

    // Random toggling with a varying consumer duty cycle
    do_clear(1'b0);
    held = 2;
    for (int blk = 0; blk < 6; blk++) begin
      thr = $urandom_range(0, 100);
      for (int c = 0; c < 300; c++) begin
        if (held >= 2 && $urandom_range(0, 2) == 0) begin
          toggle = ~toggle;
          held   = 0;
        end
        ready = ($urandom_range(0, 99) < thr);
        cycle();
        held++;
      end
    end
    ready = 1'b0;

    // T6: clear mid-stream with the toggle line left high
    do_clear(1'b0);
    flips(3, 3);
    run(3);
    chk("t6_pending3", 32'(pending), 32'd3);
    do_clear(1'b1);
    run(S);
    chk("t6_pre_event", 32'(pending), 32'd0);
    cycle();
    chk("t6_count", 32'(count), 32'd1);
    chk("t6_pending", 32'(pending), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
